// File: rtl/vec_reg_bank_pkg.sv
// rtl/vec_reg_bank_pkg.sv - shared widths, lane types and lane-merge helper for vec_reg_bank
package vec_reg_pkg;

   localparam int DEFAULT_XLEN  = 32;
   localparam int DEFAULT_LANES = 4;

   typedef logic [DEFAULT_XLEN-1:0]               lane_t;
   typedef logic [DEFAULT_LANES*DEFAULT_XLEN-1:0] vec_t;

   // Top scalar index doubles as the display register.
   function automatic int VGA_IDX(input int nsreg);
      return nsreg - 1;
   endfunction

   function automatic vec_t lane_merge(input vec_t                     old,
                                       input vec_t                     wdata,
                                       input logic [DEFAULT_LANES-1:0] mask,
                                       input logic                     splat);
      vec_t  res;
      lane_t src;
      res = old;
      for (int i = 0; i < DEFAULT_LANES; i++) begin
         src = splat ? wdata[DEFAULT_XLEN-1:0] : wdata[i*DEFAULT_XLEN +: DEFAULT_XLEN];
         if (mask[i]) res[i*DEFAULT_XLEN +: DEFAULT_XLEN] = src;
      end
      return res;
   endfunction

endpackage

// File: rtl/vec_reg_bank_if.sv
// rtl/vec_reg_bank_if.sv - scalar/vector register bank access bus
interface vec_reg_bank_if
   import vec_reg_pkg::*;
#(
   parameter int XLEN  = DEFAULT_XLEN,
   parameter int NSREG = 16,
   parameter int NVREG = 4,
   parameter int LANES = DEFAULT_LANES,
   parameter int SAW   = $clog2(NSREG),
   parameter int VAW   = $clog2(NVREG)
);

   logic                  s_we;
   logic [SAW-1:0]        s_wa;
   logic [XLEN-1:0]       s_wd;
   logic [SAW-1:0]        s_ra1;
   logic [SAW-1:0]        s_ra2;
   logic [XLEN-1:0]       s_rd1;
   logic [XLEN-1:0]       s_rd2;

   logic                  v_we;
   logic [VAW-1:0]        v_wa;
   logic [LANES-1:0]      v_wmask;
   logic                  v_splat;
   logic [LANES*XLEN-1:0] v_wd;
   logic [VAW-1:0]        v_ra1;
   logic [VAW-1:0]        v_ra2;
   logic [LANES*XLEN-1:0] v_rd1;
   logic [LANES*XLEN-1:0] v_rd2;

   logic                  sb_set;
   logic [VAW-1:0]        sb_idx;
   logic [NVREG-1:0]      sb_busy;
   logic [XLEN-1:0]       r_vga;

   modport master (
      output s_we, s_wa, s_wd, s_ra1, s_ra2,
      output v_we, v_wa, v_wmask, v_splat, v_wd, v_ra1, v_ra2,
      output sb_set, sb_idx,
      input  s_rd1, s_rd2, v_rd1, v_rd2, sb_busy, r_vga
   );

   modport slave (
      input  s_we, s_wa, s_wd, s_ra1, s_ra2,
      input  v_we, v_wa, v_wmask, v_splat, v_wd, v_ra1, v_ra2,
      input  sb_set, sb_idx,
      output s_rd1, s_rd2, v_rd1, v_rd2, sb_busy, r_vga
   );

endinterface

// File: rtl/vec_reg_bank_scoreboard.sv
// rtl/vec_reg_bank_scoreboard.sv - per-vector-register busy bits, set wins over clear
module vec_scoreboard #(
   parameter int NVREG = 4,
   parameter int VAW   = $clog2(NVREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [VAW-1:0]   set_idx,
   input  logic             clr,
   input  logic [VAW-1:0]   clr_idx,
   output logic [NVREG-1:0] busy
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NVREG; i++) begin
            // A new issue to the same register overrides the completing write.
            if (set && int'(set_idx) == i)
               busy[i] <= 1'b1;
            else if (clr && int'(clr_idx) == i)
               busy[i] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/vec_reg_bank.sv
// rtl/vec_reg_bank.sv - scalar + vector register bank with display register; option REG_BANK_BYPASS_EN
module vec_reg_bank
   import vec_reg_pkg::*;
#(
   parameter int XLEN  = DEFAULT_XLEN,
   parameter int NSREG = 16,
   parameter int NVREG = 4,
   parameter int LANES = DEFAULT_LANES,
   parameter int SAW   = $clog2(NSREG),
   parameter int VAW   = $clog2(NVREG)
) (
   input logic           clk,
   input logic           rst,
   vec_reg_bank_if.slave bus
);

   localparam int VGA = VGA_IDX(NSREG);
   localparam int VW  = LANES * XLEN;

   // Display register lives outside the array so it can drive r_vga directly.
   logic [XLEN-1:0] sreg [VGA];
   logic [XLEN-1:0] r_vga_q;
   logic [VW-1:0]   vreg [NVREG];
   logic [VW-1:0]   v_merged;

   function automatic logic [XLEN-1:0] s_get(input logic [SAW-1:0] a);
      logic [XLEN-1:0] r;
      r = '0;
      if (int'(a) == VGA)
         r = r_vga_q;
      else if (int'(a) < VGA)
         r = sreg[a];
      return r;
   endfunction

   function automatic logic [VW-1:0] v_get(input logic [VAW-1:0] a);
      logic [VW-1:0] r;
      r = '0;
      if (int'(a) < NVREG) r = vreg[a];
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < VGA; i++) sreg[i] <= '0;
         r_vga_q <= '0;
      end else if (bus.s_we) begin
         for (int i = 0; i < VGA; i++)
            if (int'(bus.s_wa) == i) sreg[i] <= bus.s_wd;
         if (int'(bus.s_wa) == VGA) r_vga_q <= bus.s_wd;
      end
   end

   assign v_merged = lane_merge(v_get(bus.v_wa), bus.v_wd, bus.v_wmask, bus.v_splat);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NVREG; i++) vreg[i] <= '0;
      end else if (bus.v_we) begin
         for (int i = 0; i < NVREG; i++)
            if (int'(bus.v_wa) == i) vreg[i] <= v_merged;
      end
   end

`ifdef REG_BANK_BYPASS_EN
   logic s_wr_ok;
   logic v_wr_ok;

   // Forward only writes that will actually land in storage.
   assign s_wr_ok   = bus.s_we && (int'(bus.s_wa) <= VGA);
   assign v_wr_ok   = bus.v_we && (int'(bus.v_wa) < NVREG);
   assign bus.s_rd1 = (s_wr_ok && bus.s_ra1 == bus.s_wa) ? bus.s_wd : s_get(bus.s_ra1);
   assign bus.s_rd2 = (s_wr_ok && bus.s_ra2 == bus.s_wa) ? bus.s_wd : s_get(bus.s_ra2);
   assign bus.v_rd1 = (v_wr_ok && bus.v_ra1 == bus.v_wa) ? v_merged : v_get(bus.v_ra1);
   assign bus.v_rd2 = (v_wr_ok && bus.v_ra2 == bus.v_wa) ? v_merged : v_get(bus.v_ra2);
`else
   assign bus.s_rd1 = s_get(bus.s_ra1);
   assign bus.s_rd2 = s_get(bus.s_ra2);
   assign bus.v_rd1 = v_get(bus.v_ra1);
   assign bus.v_rd2 = v_get(bus.v_ra2);
`endif

   assign bus.r_vga = r_vga_q;

   vec_scoreboard #(
      .NVREG (NVREG),
      .VAW   (VAW)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .set     (bus.sb_set),
      .set_idx (bus.sb_idx),
      .clr     (bus.v_we),
      .clr_idx (bus.v_wa),
      .busy    (bus.sb_busy)
   );

endmodule
